// File: rtl/rect_pkg.sv
// rect_pkg: shared mode encoding, button codes and playfield/player defaults
package rect_pkg;
  typedef enum logic [1:0] {
    M_STATIC   = 2'd0,
    M_MANUAL   = 2'd1,
    M_PATROL_H = 2'd2,
    M_PATROL_V = 2'd3
  } mode_e;
  localparam logic [3:0] BTN_UP    = 4'b1000;
  localparam logic [3:0] BTN_DOWN  = 4'b0100;
  localparam logic [3:0] BTN_RIGHT = 4'b0010;
  localparam logic [3:0] BTN_LEFT  = 4'b0001;
  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;
  localparam int DEF_P_W   = 12;
  localparam int DEF_P_H   = 12;
endpackage

// File: rtl/rect_collide.sv
// rect_collide: combinational player/rectangle contact flags and overlap-with-mismatch condition
// Ports: i_px/i_py player corner, i_rx/i_ry rect corner, i_w/i_h rect size,
//        i_rc/i_pc colours, i_vis rect visible; o_up/o_down/o_left/o_right block flags,
//        o_ov overlapping with a colour mismatch.
module rect_collide #(
  parameter int CW  = 10,
  parameter int P_W = 12,
  parameter int P_H = 12
) (
  input  logic [CW-1:0] i_px,
  input  logic [CW-1:0] i_py,
  input  logic [CW-1:0] i_rx,
  input  logic [CW-1:0] i_ry,
  input  logic [CW-1:0] i_w,
  input  logic [CW-1:0] i_h,
  input  logic [3:0]    i_rc,
  input  logic [3:0]    i_pc,
  input  logic          i_vis,
  output logic          o_up,
  output logic          o_down,
  output logic          o_left,
  output logic          o_right,
  output logic          o_ov
);
  // One extra bit so the far edges never wrap around
  logic [CW:0] w_pl, w_pt, w_pr, w_pb, w_rl, w_rt, w_rr, w_rb;
  logic w_hov, w_vov, w_full_h, w_full_v, w_mis;
  assign w_pl = {1'b0, i_px};
  assign w_pt = {1'b0, i_py};
  assign w_rl = {1'b0, i_rx};
  assign w_rt = {1'b0, i_ry};
  assign w_pr = w_pl + (CW+1)'(P_W);
  assign w_pb = w_pt + (CW+1)'(P_H);
  assign w_rr = w_rl + {1'b0, i_w};
  assign w_rb = w_rt + {1'b0, i_h};
  assign w_hov    = w_pr > w_rl && w_pl < w_rr;
  assign w_vov    = w_pb > w_rt && w_pt < w_rb;
  assign w_full_h = w_pl >= w_rl && w_pr <= w_rr;
  assign w_full_v = w_pt >= w_rt && w_pb <= w_rb;
  assign w_mis    = i_rc != i_pc;
  // A matching-colour player fully inside the span may pass through the edge
  assign o_down  = i_vis && w_pb == w_rt && w_hov && (w_mis || !w_full_h);
  assign o_up    = i_vis && w_pt == w_rb && w_hov && (w_mis || !w_full_h);
  assign o_right = i_vis && w_pr == w_rl && w_vov && (w_mis || !w_full_v);
  assign o_left  = i_vis && w_pl == w_rr && w_vov && (w_mis || !w_full_v);
  assign o_ov    = i_vis && w_hov && w_vov && w_mis;
endmodule

// File: rtl/rect_obstacle.sv
// rect_obstacle: movable rectangle obstacle (static/manual/patrol) with registered player block flags and hit pulse
// Ports: btnClk clock, rst_n async active-low reset, load/step_tick strobes, mode, btns,
//        x0/y0/w/h geometry, visible, colours, player_x/player_y; outputs rect_x/rect_y,
//        blk_up/down/left/right, hit, dir.
module rect_obstacle
  import rect_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES,
  parameter int CW    = 10,
  parameter int P_W   = DEF_P_W,
  parameter int P_H   = DEF_P_H,
  parameter int STEP  = 1,
  parameter int WRAP  = 1
) (
  input  logic          btnClk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step_tick,
  input  logic [1:0]    mode,
  input  logic [3:0]    btns,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] w,
  input  logic [CW-1:0] h,
  input  logic          visible,
  input  logic [3:0]    rect_color,
  input  logic [3:0]    player_color,
  input  logic [CW-1:0] player_x,
  input  logic [CW-1:0] player_y,
  output logic [CW-1:0] rect_x,
  output logic [CW-1:0] rect_y,
  output logic          blk_up,
  output logic          blk_down,
  output logic          blk_left,
  output logic          blk_right,
  output logic          hit,
  output logic          dir
);
  localparam int SW = CW + 1;
  mode_e r_mode;
  logic [CW-1:0] r_x, r_y;
  logic r_dir, r_ov, r_hit, r_up, r_down, r_left, r_right;
  logic signed [SW-1:0] w_xs, w_ys, w_step, w_hi_x, w_hi_y, w_mx, w_my;
  logic signed [SW-1:0] w_pv, w_phi, w_praw, w_pn;
  logic w_pturn, w_chg, w_up, w_down, w_left, w_right, w_ov;
  // Upper bound of the top-left corner; an oversized rectangle pins it at 0
  function automatic logic signed [SW-1:0] f_hi(input int res, input logic [CW-1:0] sz);
    logic signed [SW-1:0] d;
    d = $signed(SW'(res)) - $signed({1'b0, sz});
    return d < 0 ? '0 : d;
  endfunction
  function automatic logic signed [SW-1:0] f_fit(input logic signed [SW-1:0] v,
                                                 input logic signed [SW-1:0] hi);
    return v < 0 ? (WRAP != 0 ? hi : '0) : v > hi ? (WRAP != 0 ? '0 : hi) : v;
  endfunction
  always_comb begin
    w_xs    = $signed({1'b0, r_x});
    w_ys    = $signed({1'b0, r_y});
    w_step  = $signed(SW'(STEP));
    w_hi_x  = f_hi(H_RES, w);
    w_hi_y  = f_hi(V_RES, h);
    w_mx    = btns == BTN_LEFT  ? f_fit(w_xs - w_step, w_hi_x) :
              btns == BTN_RIGHT ? f_fit(w_xs + w_step, w_hi_x) : w_xs;
    w_my    = btns == BTN_UP    ? f_fit(w_ys - w_step, w_hi_y) :
              btns == BTN_DOWN  ? f_fit(w_ys + w_step, w_hi_y) : w_ys;
    // Patrol shares one datapath; the mode picks the axis
    w_pv    = r_mode == M_PATROL_V ? w_ys : w_xs;
    w_phi   = r_mode == M_PATROL_V ? w_hi_y : w_hi_x;
    w_praw  = r_dir ? w_pv - w_step : w_pv + w_step;
    w_pturn = w_praw < 0 || w_praw > w_phi;
    w_pn    = w_praw < 0 ? '0 : w_praw > w_phi ? w_phi : w_praw;
    w_chg   = mode_e'(mode) != r_mode;
  end
  rect_collide #(.CW(CW), .P_W(P_W), .P_H(P_H)) u_collide (
    .i_px(player_x), .i_py(player_y), .i_rx(r_x), .i_ry(r_y), .i_w(w), .i_h(h),
    .i_rc(rect_color), .i_pc(player_color), .i_vis(visible),
    .o_up(w_up), .o_down(w_down), .o_left(w_left), .o_right(w_right), .o_ov(w_ov)
  );
  always_ff @(posedge btnClk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_dir   <= 1'b0;
      r_mode  <= M_STATIC;
      r_ov    <= 1'b0;
      r_hit   <= 1'b0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_left  <= 1'b0;
      r_right <= 1'b0;
    end else begin
      r_up    <= w_up;
      r_down  <= w_down;
      r_left  <= w_left;
      r_right <= w_right;
      r_ov    <= w_ov;
      r_hit   <= w_ov && !r_ov;
      if (load) begin
        r_x    <= x0;
        r_y    <= y0;
        r_mode <= mode_e'(mode);
        if (w_chg) r_dir <= 1'b0;
      end else if (step_tick) begin
        // The step acts on the mode already held; the sampled mode applies from the next step
        r_mode <= mode_e'(mode);
        r_dir  <= w_chg ? 1'b0 :
                  (r_mode == M_PATROL_H || r_mode == M_PATROL_V) && w_pturn ? ~r_dir : r_dir;
        r_x    <= r_mode == M_MANUAL ? w_mx[CW-1:0] : r_mode == M_PATROL_H ? w_pn[CW-1:0] : r_x;
        r_y    <= r_mode == M_MANUAL ? w_my[CW-1:0] : r_mode == M_PATROL_V ? w_pn[CW-1:0] : r_y;
      end
    end
  end
  assign rect_x    = r_x;
  assign rect_y    = r_y;
  assign dir       = r_dir;
  assign hit       = r_hit;
  assign blk_up    = r_up;
  assign blk_down  = r_down;
  assign blk_left  = r_left;
  assign blk_right = r_right;
endmodule

// File: tb/tb_rect_obstacle.sv
// tb_rect_obstacle: directed self-checking bench for rect_obstacle (wrap, saturate and step-4 variants)
module tb_rect_obstacle;
  logic clk = 1'b0;
  logic rst_n, load, step_tick, visible;
  logic [1:0] mode;
  logic [3:0] btns, rect_color, player_color;
  logic [9:0] x0, y0, w, h, player_x, player_y;
  logic [9:0] rx [3];
  logic [9:0] ry [3];
  logic bu [3];
  logic bd [3];
  logic bl [3];
  logic br [3];
  logic ht [3];
  logic dr [3];
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  rect_obstacle u0 (
    .btnClk(clk), .rst_n(rst_n), .load(load), .step_tick(step_tick), .mode(mode), .btns(btns),
    .x0(x0), .y0(y0), .w(w), .h(h), .visible(visible), .rect_color(rect_color),
    .player_color(player_color), .player_x(player_x), .player_y(player_y),
    .rect_x(rx[0]), .rect_y(ry[0]), .blk_up(bu[0]), .blk_down(bd[0]), .blk_left(bl[0]),
    .blk_right(br[0]), .hit(ht[0]), .dir(dr[0]));
  rect_obstacle #(.WRAP(0)) u1 (
    .btnClk(clk), .rst_n(rst_n), .load(load), .step_tick(step_tick), .mode(mode), .btns(btns),
    .x0(x0), .y0(y0), .w(w), .h(h), .visible(visible), .rect_color(rect_color),
    .player_color(player_color), .player_x(player_x), .player_y(player_y),
    .rect_x(rx[1]), .rect_y(ry[1]), .blk_up(bu[1]), .blk_down(bd[1]), .blk_left(bl[1]),
    .blk_right(br[1]), .hit(ht[1]), .dir(dr[1]));
  rect_obstacle #(.STEP(4)) u2 (
    .btnClk(clk), .rst_n(rst_n), .load(load), .step_tick(step_tick), .mode(mode), .btns(btns),
    .x0(x0), .y0(y0), .w(w), .h(h), .visible(visible), .rect_color(rect_color),
    .player_color(player_color), .player_x(player_x), .player_y(player_y),
    .rect_x(rx[2]), .rect_y(ry[2]), .blk_up(bu[2]), .blk_down(bd[2]), .blk_left(bl[2]),
    .blk_right(br[2]), .hit(ht[2]), .dir(dr[2]));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [9:0] x, input logic [9:0] y, input logic [1:0] m);
    x0 = x; y0 = y; mode = m; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask
  task automatic do_tick(input int n);
    repeat (n) begin
      step_tick = 1'b1;
      cyc();
      step_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; step_tick = 1'b0; mode = 2'd1; btns = 4'd2;
    x0 = 10'd77; y0 = 10'd66; w = 10'd40; h = 10'd40; visible = 1'b1;
    rect_color = 4'd3; player_color = 4'd5; player_x = 10'd0; player_y = 10'd0;
    #12;
    vecs++; if (rx[0] !== 10'd0 || ry[0] !== 10'd0) begin errs++; $display("FAIL reset_pos got (%0d,%0d) want (0,0)", rx[0], ry[0]); end
    vecs++; if (dr[0] !== 1'b0 || ht[0] !== 1'b0) begin errs++; $display("FAIL reset_dir_hit got dir=%b hit=%b want 0,0", dr[0], ht[0]); end
    vecs++; if ({bu[0], bd[0], bl[0], br[0]} !== 4'b0) begin errs++; $display("FAIL reset_flags got %b want 0000", {bu[0], bd[0], bl[0], br[0]}); end
    @(negedge clk); rst_n = 1'b1;
    cyc(); cyc();
    vecs++; if (rx[0] !== 10'd0 || ry[0] !== 10'd0) begin errs++; $display("FAIL reset_idle got (%0d,%0d) want (0,0)", rx[0], ry[0]); end
  endtask

  task automatic test_manual();
    do_load(10'd100, 10'd50, 2'd1);
    btns = 4'd2; do_tick(3);
    vecs++; if (rx[0] !== 10'd103 || ry[0] !== 10'd50) begin errs++; $display("FAIL manual_right got (%0d,%0d) want (103,50)", rx[0], ry[0]); end
    btns = 4'd4; do_tick(1);
    vecs++; if (ry[0] !== 10'd51) begin errs++; $display("FAIL manual_down got %0d want 51", ry[0]); end
    btns = 4'd8; do_tick(1);
    vecs++; if (ry[0] !== 10'd50) begin errs++; $display("FAIL manual_up got %0d want 50", ry[0]); end
    btns = 4'd1; do_tick(1);
    vecs++; if (rx[0] !== 10'd102) begin errs++; $display("FAIL manual_left got %0d want 102", rx[0]); end
    btns = 4'd3; do_tick(1);
    vecs++; if (rx[0] !== 10'd102 || ry[0] !== 10'd50) begin errs++; $display("FAIL manual_not_onehot got (%0d,%0d) want (102,50)", rx[0], ry[0]); end
  endtask

  task automatic test_wrap();
    do_load(10'd0, 10'd0, 2'd1);
    btns = 4'd1; do_tick(1);
    vecs++; if (rx[0] !== 10'd600) begin errs++; $display("FAIL wrap_left got %0d want 600", rx[0]); end
    vecs++; if (rx[1] !== 10'd0) begin errs++; $display("FAIL sat_left got %0d want 0", rx[1]); end
    btns = 4'd8; do_tick(1);
    vecs++; if (ry[0] !== 10'd440 || ry[1] !== 10'd0) begin errs++; $display("FAIL edge_up got wrap=%0d sat=%0d want 440,0", ry[0], ry[1]); end
    do_load(10'd600, 10'd440, 2'd1);
    btns = 4'd2; do_tick(1);
    vecs++; if (rx[0] !== 10'd0 || rx[1] !== 10'd600) begin errs++; $display("FAIL edge_right got wrap=%0d sat=%0d want 0,600", rx[0], rx[1]); end
    btns = 4'd4; do_tick(1);
    vecs++; if (ry[0] !== 10'd0 || ry[1] !== 10'd440) begin errs++; $display("FAIL edge_down got wrap=%0d sat=%0d want 0,440", ry[0], ry[1]); end
  endtask

  task automatic test_patrol();
    btns = 4'd0;
    do_load(10'd598, 10'd0, 2'd2);
    do_tick(1);
    vecs++; if (rx[2] !== 10'd600 || dr[2] !== 1'b1) begin errs++; $display("FAIL patrol_h_hi got x=%0d dir=%b want 600,1", rx[2], dr[2]); end
    do_tick(1);
    vecs++; if (rx[2] !== 10'd596 || dr[2] !== 1'b1) begin errs++; $display("FAIL patrol_h_back got x=%0d dir=%b want 596,1", rx[2], dr[2]); end
    do_load(10'd0, 10'd438, 2'd3);
    vecs++; if (dr[2] !== 1'b0) begin errs++; $display("FAIL mode_change_dir got %b want 0", dr[2]); end
    do_tick(1);
    vecs++; if (ry[2] !== 10'd440 || dr[2] !== 1'b1 || rx[2] !== 10'd0) begin errs++; $display("FAIL patrol_v_hi got (%0d,%0d) dir=%b want (0,440) 1", rx[2], ry[2], dr[2]); end
    do_load(10'd0, 10'd2, 2'd3);
    vecs++; if (dr[2] !== 1'b1) begin errs++; $display("FAIL same_mode_dir got %b want 1", dr[2]); end
    do_tick(1);
    vecs++; if (ry[2] !== 10'd0 || dr[2] !== 1'b0) begin errs++; $display("FAIL patrol_v_lo got y=%0d dir=%b want 0,0", ry[2], dr[2]); end
  endtask

  task automatic test_collide();
    player_x = 10'd300; player_y = 10'd300; rect_color = 4'd3; player_color = 4'd5; visible = 1'b1;
    do_load(10'd100, 10'd100, 2'd0);
    btns = 4'd2; do_tick(1);
    vecs++; if (rx[0] !== 10'd100) begin errs++; $display("FAIL static_ignore got %0d want 100", rx[0]); end
    player_x = 10'd110; player_y = 10'd88; #1;
    vecs++; if (bd[0] !== 1'b0) begin errs++; $display("FAIL flag_latency got %b want 0", bd[0]); end
    cyc();
    vecs++; if ({bu[0], bd[0], bl[0], br[0]} !== 4'b0100) begin errs++; $display("FAIL blk_down_mis got %b want 0100", {bu[0], bd[0], bl[0], br[0]}); end
    player_color = 4'd3; cyc();
    vecs++; if (bd[0] !== 1'b0) begin errs++; $display("FAIL blk_down_match got %b want 0", bd[0]); end
    player_x = 10'd95; cyc();
    vecs++; if (bd[0] !== 1'b1) begin errs++; $display("FAIL blk_down_partial got %b want 1", bd[0]); end
    player_color = 4'd5; player_x = 10'd88; player_y = 10'd110; cyc();
    vecs++; if ({bu[0], bd[0], bl[0], br[0]} !== 4'b0001) begin errs++; $display("FAIL blk_right got %b want 0001", {bu[0], bd[0], bl[0], br[0]}); end
    player_x = 10'd110; player_y = 10'd140; cyc();
    vecs++; if ({bu[0], bd[0], bl[0], br[0]} !== 4'b1000) begin errs++; $display("FAIL blk_up got %b want 1000", {bu[0], bd[0], bl[0], br[0]}); end
    player_x = 10'd140; player_y = 10'd110; cyc();
    vecs++; if ({bu[0], bd[0], bl[0], br[0]} !== 4'b0010) begin errs++; $display("FAIL blk_left got %b want 0010", {bu[0], bd[0], bl[0], br[0]}); end
  endtask

  task automatic test_hit();
    player_x = 10'd200; player_y = 10'd200; cyc(); cyc();
    vecs++; if (ht[0] !== 1'b0) begin errs++; $display("FAIL hit_idle got %b want 0", ht[0]); end
    player_x = 10'd110; player_y = 10'd110; cyc();
    vecs++; if (ht[0] !== 1'b1) begin errs++; $display("FAIL hit_pulse got %b want 1", ht[0]); end
    cyc();
    vecs++; if (ht[0] !== 1'b0) begin errs++; $display("FAIL hit_once got %b want 0", ht[0]); end
    visible = 1'b0; player_x = 10'd200; player_y = 10'd200; cyc(); cyc();
    player_x = 10'd110; player_y = 10'd110; cyc();
    vecs++; if (ht[0] !== 1'b0) begin errs++; $display("FAIL hit_invisible got %b want 0", ht[0]); end
    player_y = 10'd88; cyc();
    vecs++; if ({bu[0], bd[0], bl[0], br[0], ht[0]} !== 5'b0) begin errs++; $display("FAIL flags_invisible got %b want 00000", {bu[0], bd[0], bl[0], br[0], ht[0]}); end
    visible = 1'b1;
  endtask

  task automatic test_load_priority();
    btns = 4'd4; x0 = 10'd200; y0 = 10'd150; mode = 2'd1;
    load = 1'b1; step_tick = 1'b1; cyc();
    load = 1'b0; step_tick = 1'b0;
    vecs++; if (rx[0] !== 10'd200 || ry[0] !== 10'd150) begin errs++; $display("FAIL load_priority got (%0d,%0d) want (200,150)", rx[0], ry[0]); end
  endtask

  task automatic test_async_reset();
    btns = 4'd2; step_tick = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    vecs++; if (rx[0] !== 10'd0 || ry[0] !== 10'd0 || dr[0] !== 1'b0) begin errs++; $display("FAIL async_reset got (%0d,%0d) dir=%b want (0,0) 0", rx[0], ry[0], dr[0]); end
    step_tick = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cyc(); cyc(); cyc();
    vecs++; if (rx[0] !== 10'd0 || ry[0] !== 10'd0) begin errs++; $display("FAIL post_reset_still got (%0d,%0d) want (0,0)", rx[0], ry[0]); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_wrap();
    test_patrol();
    test_collide();
    test_hit();
    test_load_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
